scoreboard: RTL and testbench
=============================

Name: scoreboard

Overview:
- Register/predicate scoreboard feeding the decode stage.
- Records every destination write that decode issues: GPR r0..r31 and predicates p0..p2 (p3 is constant-true and never tracked).
- Clears each entry when its result writes back.
- Exposes pending state as sb2d_reg_scoreboard / sb2d_pred_scoreboard, which decode uses for dep_stall.
- Handles pipeline flush, idle detection and protocol-error detection.

Parameters:
LANES, 4, issue slots per packet (one decode instance per lane)
WB_PORTS, 4, writeback ports (ALU, LSU, mult/div, branch-link)

Ports:
clkrst_core_clk  input  1  core clock; single clock domain
clkrst_core_rst  input  1  synchronous, active-high reset
d2sb_issue  input  LANES  lane issues this cycle (valid and not stalled)
d2sb_rd_num  input  5*LANES  lane destination number; lane i at [5i+4:5i]
d2sb_rd_we  input  LANES  lane writes GPR rd_num
d2sb_pred_we  input  LANES  lane writes predicate rd_num[1:0]
d2sb_oper_type  input  2*LANES  lane oper type, OPER_TYPE_* encoding
wb2sb_valid  input  WB_PORTS  writeback port completes this cycle
wb2sb_num  input  5*WB_PORTS  writeback destination number
wb2sb_pred  input  WB_PORTS  1 = target is predicate wb2sb_num[1:0]; 0 = GPR
flush  input  1  pipeline squash
sb2d_reg_scoreboard  output  32  bit r set = GPR r pending
sb2d_pred_scoreboard  output  3  bit p set = predicate p pending
sb_idle  output  1  no entry pending
sb_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset: all pending bits 0; all owner tags OPER_TYPE_ALU; sb_idle=1; sb_err=0. Reset mid-operation discards all state, with no drain.
- State: 35 entries, each holding a pending bit and a 2-bit owner tag (oper type of the issuing instruction).
- Outputs come directly from state registers. Latency is 1 cycle: an event at edge N is visible after edge N+1. There is no combinational bypass from inputs to outputs.
- Issue:
  - d2sb_issue[i] & d2sb_rd_we[i] sets reg entry rd_num and writes its owner = oper_type.
  - d2sb_issue[i] & d2sb_pred_we[i] sets pred entry rd_num[1:0]; owner = oper_type.
  - rd_num[1:0]==3 with pred_we is ignored (no set, no error).
  - A lane with issue=0, or with both we=0, does nothing.
  - rd_we and pred_we both set in one lane: sb_err is set; the GPR is set and the predicate is not.
- Writeback: wb2sb_valid[k] clears the addressed entry. A pred writeback to index 3 is ignored.
- Same-cycle precedence per entry, highest first:
  1. reset
  2. flush (for entries it clears; issues are ignored that cycle)
  3. issue set
  4. writeback clear
  A writeback and an issue to the same entry in one cycle leave it pending, owned by the new issue.
- Flush:
  - Clears every pending entry whose owner is OPER_TYPE_ALU or OPER_TYPE_BRANCH, because those results are squashed.
  - Entries owned by OPER_TYPE_LSU or OPER_TYPE_OTHER stay pending until their writeback arrives, because those units complete regardless.
  - All issues in a flush cycle are dropped.
  - Writebacks in a flush cycle still apply.
- sb_idle = NOR of all 35 pending bits, computed from registered state.
- sb_err is set, and stays set until reset, on any of:
  - a writeback to an entry not pending and not being issued that cycle;
  - an issue to an entry already pending and not being cleared that cycle (decode should have stalled);
  - two lanes issuing the same entry in one cycle;
  - a single lane with both rd_we and pred_we.
- On every error the set/clear actions still execute as specified above.
- Multiple writebacks to the same entry in one cycle: the entry clears and sb_err is set.

Decomposition:
- Shared package/include oper_type.vh, already present, supplies OPER_TYPE_ALU/LSU/BRANCH/OTHER. Add SB_NUM_PREDS=3 there.
- Sub-module scoreboard_entry: one pending bit plus owner tag. Inputs: set, set_owner, clr, flush, rst. Outputs: pending, owner, err_dup_set, err_bad_clr. Instantiated 32× for GPRs and 3× for predicates.
- Top level does the per-entry decode/OR-reduction of lanes and ports and the error aggregation.

Test Plan:
- Reset for 2 cycles -> reg_scoreboard=32'h0, pred_scoreboard=3'b000, sb_idle=1, sb_err=0.
- Lane0 issue rd=5, rd_we, ALU -> next cycle bit5=1, sb_idle=0; then wb port0 num=5 -> next cycle reg_scoreboard=0, sb_idle=1.
- r7 pending; same cycle wb num=7 and lane2 issue rd=7, LSU -> bit7 stays 1, owner LSU, sb_err=0.
- Pending r3 (ALU), r4 (LSU), p1 (ALU), r31 (BRANCH); flush together with lane1 issue r9 -> r3, p1, r31 cleared, r4=1, r9=0; later wb r4 -> sb_idle=1.
- Wb to non-pending r9 -> sb_err=1 and stays 1 for 10 cycles. After reset, lanes 0 and 3 both issue rd=2 -> bit2=1, sb_err=1.
- Lane0 pred_we rd_num=3 -> no bit set, sb_err=0. Then issue p0, p2 and r1, assert reset mid-stream -> all zero next cycle.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register/predicate scoreboard.
// Contents: oper type encoding, entry counts, field widths, flush squash helper.
package scoreboard_pkg;

  localparam int unsigned SB_NUM_REGS    = 32;
  localparam int unsigned SB_NUM_PREDS   = 3;
  localparam int unsigned SB_NUM_ENTRIES = SB_NUM_REGS + SB_NUM_PREDS;
  localparam int unsigned SB_NUM_W       = 5;
  localparam int unsigned SB_OPER_W      = 2;

  typedef enum logic [SB_OPER_W-1:0] {
    OPER_TYPE_ALU    = 2'd0,
    OPER_TYPE_LSU    = 2'd1,
    OPER_TYPE_BRANCH = 2'd2,
    OPER_TYPE_OTHER  = 2'd3
  } oper_type_e;

  // Results from these units are discarded by a flush; LSU/OTHER still complete.
  function automatic logic oper_squashable(oper_type_e t);
    return (t == OPER_TYPE_ALU) || (t == OPER_TYPE_BRANCH);
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard entry: pending bit plus the oper type of the instruction that owns it.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   set_i, set_owner_i  issue sets the entry and records the owner
//   clr_i               writeback clears the entry
//   flush_i             squash this entry (already qualified by owner at the top)
//   pending_o, owner_o  registered state
//   err_dup_set_c_o     issue to an entry already pending and not being cleared
//   err_bad_clr_c_o     writeback to an entry neither pending nor being issued
module scoreboard_entry
  import scoreboard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  oper_type_e set_owner_i,
  input  logic       clr_i,
  input  logic       flush_i,
  output logic       pending_o,
  output oper_type_e owner_o,
  output logic       err_dup_set_c_o,
  output logic       err_bad_clr_c_o
);

  logic       pending_q, pending_d;
  oper_type_e owner_q, owner_d;

  // Next state: flush > issue set > writeback clear.
  always_comb begin
    pending_d = pending_q;
    owner_d   = owner_q;
    if (flush_i) begin
      pending_d = 1'b0;
    end else if (set_i) begin
      pending_d = 1'b1;
      owner_d   = set_owner_i;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      owner_q   <= OPER_TYPE_ALU;
    end else begin
      pending_q <= pending_d;
      owner_q   <= owner_d;
    end
  end

  assign err_dup_set_c_o = set_i & pending_q & ~clr_i;
  assign err_bad_clr_c_o = clr_i & ~pending_q & ~set_i;

  assign pending_o = pending_q;
  assign owner_o   = owner_q;

endmodule

// File: rtl/scoreboard.sv
// Register/predicate scoreboard for decode: tracks pending GPR r0..r31 and
// predicates p0..p2 from issue to writeback, with flush, idle and error detection.
// Ports:
//   clkrst_core_clk/rst     clock, synchronous active-high reset
//   d2sb_*                  per-lane issue: valid, rd number, GPR/pred write enables, oper type
//   wb2sb_*                 per-port writeback: valid, number, predicate select
//   flush                   pipeline squash
//   sb2d_reg_scoreboard     pending GPR bits
//   sb2d_pred_scoreboard    pending predicate bits
//   sb_idle                 nothing pending
//   sb_err                  sticky protocol-violation flag
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned WB_PORTS = 4
) (
  input  logic                           clkrst_core_clk,
  input  logic                           clkrst_core_rst,
  input  logic [LANES-1:0]               d2sb_issue,
  input  logic [SB_NUM_W*LANES-1:0]      d2sb_rd_num,
  input  logic [LANES-1:0]               d2sb_rd_we,
  input  logic [LANES-1:0]               d2sb_pred_we,
  input  logic [SB_OPER_W*LANES-1:0]     d2sb_oper_type,
  input  logic [WB_PORTS-1:0]            wb2sb_valid,
  input  logic [SB_NUM_W*WB_PORTS-1:0]   wb2sb_num,
  input  logic [WB_PORTS-1:0]            wb2sb_pred,
  input  logic                           flush,
  output logic [SB_NUM_REGS-1:0]         sb2d_reg_scoreboard,
  output logic [SB_NUM_PREDS-1:0]        sb2d_pred_scoreboard,
  output logic                           sb_idle,
  output logic                           sb_err
);

  // Entries 0..31 are GPRs, 32..34 are predicates p0..p2.
  logic [SB_NUM_ENTRIES-1:0] ent_set, ent_set_multi;
  logic [SB_NUM_ENTRIES-1:0] ent_clr, ent_clr_multi;
  logic [SB_NUM_ENTRIES-1:0] ent_flush, ent_pend;
  logic [SB_NUM_ENTRIES-1:0] ent_err_dup, ent_err_bad;
  oper_type_e                ent_set_owner [SB_NUM_ENTRIES];
  oper_type_e                ent_owner     [SB_NUM_ENTRIES];
  logic                      lane_dual;
  int unsigned               e_idx;
  logic                      err_now;
  logic                      err_q;

  // Decode lanes and writeback ports into per-entry set/clear strobes.
  // Lanes are scanned in order, so the highest lane sets the owner on a collision.
  always_comb begin
    ent_set       = '0;
    ent_set_multi = '0;
    ent_clr       = '0;
    ent_clr_multi = '0;
    lane_dual     = 1'b0;
    e_idx         = 0;
    for (int e = 0; e < SB_NUM_ENTRIES; e++) ent_set_owner[e] = OPER_TYPE_ALU;

    // Issues are dropped entirely during a flush.
    if (!flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (d2sb_issue[i]) begin
          if (d2sb_rd_we[i] && d2sb_pred_we[i]) lane_dual = 1'b1;
          if (d2sb_rd_we[i]) begin
            e_idx = 32'(d2sb_rd_num[SB_NUM_W*i +: SB_NUM_W]);
            ent_set_multi[e_idx] = ent_set_multi[e_idx] | ent_set[e_idx];
            ent_set[e_idx]       = 1'b1;
            ent_set_owner[e_idx] = oper_type_e'(d2sb_oper_type[SB_OPER_W*i +: SB_OPER_W]);
          end else if (d2sb_pred_we[i] && (d2sb_rd_num[SB_NUM_W*i +: 2] != 2'd3)) begin
            e_idx = SB_NUM_REGS + 32'(d2sb_rd_num[SB_NUM_W*i +: 2]);
            ent_set_multi[e_idx] = ent_set_multi[e_idx] | ent_set[e_idx];
            ent_set[e_idx]       = 1'b1;
            ent_set_owner[e_idx] = oper_type_e'(d2sb_oper_type[SB_OPER_W*i +: SB_OPER_W]);
          end
        end
      end
    end

    // p3 writebacks are ignored; writebacks apply even during flush.
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wb2sb_valid[k]) begin
        if (wb2sb_pred[k]) begin
          if (wb2sb_num[SB_NUM_W*k +: 2] != 2'd3) begin
            e_idx = SB_NUM_REGS + 32'(wb2sb_num[SB_NUM_W*k +: 2]);
            ent_clr_multi[e_idx] = ent_clr_multi[e_idx] | ent_clr[e_idx];
            ent_clr[e_idx]       = 1'b1;
          end
        end else begin
          e_idx = 32'(wb2sb_num[SB_NUM_W*k +: SB_NUM_W]);
          ent_clr_multi[e_idx] = ent_clr_multi[e_idx] | ent_clr[e_idx];
          ent_clr[e_idx]       = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < SB_NUM_ENTRIES; g++) begin : g_ent
    assign ent_flush[g] = flush & oper_squashable(ent_owner[g]);

    scoreboard_entry u_entry (
      .clk_i           (clkrst_core_clk),
      .rst_i           (clkrst_core_rst),
      .set_i           (ent_set[g]),
      .set_owner_i     (ent_set_owner[g]),
      .clr_i           (ent_clr[g]),
      .flush_i         (ent_flush[g]),
      .pending_o       (ent_pend[g]),
      .owner_o         (ent_owner[g]),
      .err_dup_set_c_o (ent_err_dup[g]),
      .err_bad_clr_c_o (ent_err_bad[g])
    );
  end

  assign err_now = (|ent_set_multi) | (|ent_clr_multi) | lane_dual |
                   (|ent_err_dup) | (|ent_err_bad);

  // Sticky until reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      err_q <= 1'b0;
    end else if (err_now) begin
      err_q <= 1'b1;
    end
  end

  assign sb2d_reg_scoreboard  = ent_pend[SB_NUM_REGS-1:0];
  assign sb2d_pred_scoreboard = ent_pend[SB_NUM_ENTRIES-1:SB_NUM_REGS];
  assign sb_idle              = ~|ent_pend;
  assign sb_err               = err_q;

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: a behavioural model predicts the state
// after each edge, pushes it to a queue, and the sampled outputs are compared
// against the popped prediction.
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned WB    = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [LANES-1:0]     issue, rd_we, pred_we;
  logic [5*LANES-1:0]   rd_num;
  logic [2*LANES-1:0]   oper;
  logic [WB-1:0]        wb_valid, wb_pred;
  logic [5*WB-1:0]      wb_num;
  logic                 flush;
  logic [31:0]          reg_sb;
  logic [2:0]           pred_sb;
  logic                 idle, err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  p;
    logic        idle;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic       m_pend [35];
  logic [1:0] m_own  [35];
  logic       m_err;

  scoreboard #(.LANES(LANES), .WB_PORTS(WB)) dut (
    .clkrst_core_clk      (clk),
    .clkrst_core_rst      (rst),
    .d2sb_issue           (issue),
    .d2sb_rd_num          (rd_num),
    .d2sb_rd_we           (rd_we),
    .d2sb_pred_we         (pred_we),
    .d2sb_oper_type       (oper),
    .wb2sb_valid          (wb_valid),
    .wb2sb_num            (wb_num),
    .wb2sb_pred           (wb_pred),
    .flush                (flush),
    .sb2d_reg_scoreboard  (reg_sb),
    .sb2d_pred_scoreboard (pred_sb),
    .sb_idle              (idle),
    .sb_err               (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rst = 1'b0; flush = 1'b0;
    issue = '0; rd_we = '0; pred_we = '0; rd_num = '0; oper = '0;
    wb_valid = '0; wb_pred = '0; wb_num = '0;
  endtask

  task automatic lane(int l, int rd, bit we, bit pwe, logic [1:0] op);
    issue[l]        = 1'b1;
    rd_num[5*l +: 5] = 5'(rd);
    rd_we[l]        = we;
    pred_we[l]      = pwe;
    oper[2*l +: 2]  = op;
  endtask

  task automatic wbp(int k, int num, bit pr);
    wb_valid[k]      = 1'b1;
    wb_num[5*k +: 5] = 5'(num);
    wb_pred[k]       = pr;
  endtask

  // Behavioural model: count sets/clears per entry, then apply precedence.
  task automatic model_step();
    int         sc [35];
    int         cc [35];
    logic [1:0] no [35];
    int         e;
    logic [1:0] pi;
    if (rst) begin
      for (int j = 0; j < 35; j++) begin
        m_pend[j] = 1'b0;
        m_own[j]  = OPER_TYPE_ALU;
      end
      m_err = 1'b0;
      return;
    end
    for (int j = 0; j < 35; j++) begin
      sc[j] = 0; cc[j] = 0; no[j] = 2'd0;
    end
    if (!flush) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (issue[l]) begin
          if (rd_we[l] && pred_we[l]) m_err = 1'b1;
          pi = rd_num[5*l +: 2];
          if (rd_we[l]) begin
            e = int'(rd_num[5*l +: 5]);
            sc[e]++; no[e] = oper[2*l +: 2];
          end else if (pred_we[l] && pi != 2'd3) begin
            e = 32 + int'(pi);
            sc[e]++; no[e] = oper[2*l +: 2];
          end
        end
      end
    end
    for (int k = 0; k < int'(WB); k++) begin
      if (wb_valid[k]) begin
        pi = wb_num[5*k +: 2];
        if (wb_pred[k]) begin
          if (pi != 2'd3) cc[32 + int'(pi)]++;
        end else begin
          cc[int'(wb_num[5*k +: 5])]++;
        end
      end
    end
    for (int j = 0; j < 35; j++) begin
      if (sc[j] > 1 || cc[j] > 1) m_err = 1'b1;
      if (cc[j] > 0 && !m_pend[j] && sc[j] == 0) m_err = 1'b1;
      if (sc[j] > 0 && m_pend[j] && cc[j] == 0) m_err = 1'b1;
      if (flush && m_pend[j] && (m_own[j] == OPER_TYPE_ALU || m_own[j] == OPER_TYPE_BRANCH))
        m_pend[j] = 1'b0;
      else if (sc[j] > 0) begin
        m_pend[j] = 1'b1;
        m_own[j]  = no[j];
      end else if (cc[j] > 0)
        m_pend[j] = 1'b0;
    end
  endtask

  // Predict, clock, then compare the sampled outputs with the prediction.
  task automatic tick();
    exp_t x;
    exp_t got;
    model_step();
    x.idle = 1'b1;
    for (int j = 0; j < 35; j++) begin
      if (j < 32) x.r[j] = m_pend[j]; else x.p[j-32] = m_pend[j];
      if (m_pend[j]) x.idle = 1'b0;
    end
    x.err = m_err;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("reg_sb",  reg_sb,         got.r);
    chk("pred_sb", 32'(pred_sb),   32'(got.p));
    chk("idle",    32'(idle),      32'(got.idle));
    chk("err",     32'(err),       32'(got.err));
    clr_in();
  endtask

  initial begin
    for (int j = 0; j < 35; j++) begin
      m_pend[j] = 1'b0;
      m_own[j]  = OPER_TYPE_ALU;
    end
    m_err = 1'b0;
    clr_in();

    // Reset
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    chk("rst_reg", reg_sb, 32'h0);
    chk("rst_pred", 32'(pred_sb), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    chk("rst_err", 32'(err), 32'h0);

    // Issue r5, write it back
    lane(0, 5, 1, 0, OPER_TYPE_ALU); tick();
    chk("r5_set", 32'(reg_sb[5]), 32'h1);
    chk("r5_busy", 32'(idle), 32'h0);
    wbp(0, 5, 0); tick();
    chk("r5_clr", reg_sb, 32'h0);
    chk("r5_idle", 32'(idle), 32'h1);

    // Same-cycle writeback + reissue of r7 as LSU; LSU owner survives flush
    lane(0, 7, 1, 0, OPER_TYPE_ALU); tick();
    wbp(1, 7, 0); lane(2, 7, 1, 0, OPER_TYPE_LSU); tick();
    chk("r7_keep", 32'(reg_sb[7]), 32'h1);
    chk("r7_err", 32'(err), 32'h0);
    flush = 1'b1; tick();
    chk("r7_lsu_flush", 32'(reg_sb[7]), 32'h1);
    wbp(3, 7, 0); tick();

    // Flush squashes ALU/BRANCH owners and drops issues
    lane(0, 3, 1, 0, OPER_TYPE_ALU);
    lane(1, 4, 1, 0, OPER_TYPE_LSU);
    lane(2, 1, 0, 1, OPER_TYPE_ALU);
    lane(3, 31, 1, 0, OPER_TYPE_BRANCH);
    tick();
    chk("pre_flush_pred", 32'(pred_sb), 32'h2);
    flush = 1'b1; lane(1, 9, 1, 0, OPER_TYPE_ALU); tick();
    chk("flush_reg", reg_sb, 32'h10);
    chk("flush_pred", 32'(pred_sb), 32'h0);
    wbp(2, 4, 0); tick();
    chk("flush_idle", 32'(idle), 32'h1);

    // Writeback to non-pending r9 sets sticky error
    wbp(0, 9, 0); tick();
    chk("bad_wb_err", 32'(err), 32'h1);
    for (int c = 0; c < 10; c++) tick();
    chk("err_sticky", 32'(err), 32'h1);
    rst = 1'b1; tick();
    chk("err_rst", 32'(err), 32'h0);
    lane(0, 2, 1, 0, OPER_TYPE_ALU); lane(3, 2, 1, 0, OPER_TYPE_LSU); tick();
    chk("dup_lane_bit", 32'(reg_sb[2]), 32'h1);
    chk("dup_lane_err", 32'(err), 32'h1);

    // p3 ignored; dual write enable; mid-stream reset
    rst = 1'b1; tick();
    lane(0, 3, 0, 1, OPER_TYPE_ALU); tick();
    chk("p3_pred", 32'(pred_sb), 32'h0);
    chk("p3_err", 32'(err), 32'h0);
    lane(0, 0, 0, 1, OPER_TYPE_ALU);
    lane(1, 2, 0, 1, OPER_TYPE_LSU);
    lane(2, 1, 1, 0, OPER_TYPE_OTHER);
    tick();
    chk("p0p2", 32'(pred_sb), 32'h5);
    lane(0, 6, 1, 1, OPER_TYPE_ALU); tick();
    chk("dual_reg", 32'(reg_sb[6]), 32'h1);
    chk("dual_pred", 32'(pred_sb), 32'h5);
    chk("dual_err", 32'(err), 32'h1);
    rst = 1'b1; lane(3, 12, 1, 0, OPER_TYPE_ALU); wbp(0, 1, 0); tick();
    chk("midrst_reg", reg_sb, 32'h0);
    chk("midrst_pred", 32'(pred_sb), 32'h0);
    chk("midrst_idle", 32'(idle), 32'h1);

    // Random traffic with periodic reset
    for (int c = 0; c < 400; c++) begin
      if (c % 30 == 0) rst = 1'b1;
      for (int l = 0; l < int'(LANES); l++) begin
        if ($urandom_range(0, 2) == 0)
          lane(l, int'($urandom_range(0, 31)), bit'($urandom_range(0, 3) != 0),
               bit'($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)));
      end
      for (int k = 0; k < int'(WB); k++) begin
        if ($urandom_range(0, 2) == 0)
          wbp(k, int'($urandom_range(0, 31)), bit'($urandom_range(0, 3) == 0));
      end
      if ($urandom_range(0, 9) == 0) flush = 1'b1;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
